rom_loader_responder: RTL and testbench
=======================================

// Module: rom_loader_responder
// PURPOSE
//  SoC-side responder for the ROM-loader handshake driven by the file/host loader (reset/load/data in; load_received/ack out).
//  Accepts one instruction word per handshake and assigns it the next sequential ROM address from 0.
//  Issues one write request per word to the QSPI ROM memory controller and acks the initiator when the write completes.
//  Sits inside hack_soc between the rom_loader_* pins and the ROM write port.
// PARAMETERS
//  DATA_WIDTH     16  instruction word width
//  ADDRESS_WIDTH  16  ROM word-address width; capacity = 2**ADDRESS_WIDTH words
// PORTS
//  clk                       in   1              single clock, all state on rising edge
//  reset_n                   in   1              asynchronous, active-low reset
//  rom_loader_reset          in   1              initiator session reset: clears address/count/overflow
//  rom_loader_load           in   1              initiator: data valid, request transfer (level)
//  rom_loader_data           in   DATA_WIDTH     word to store; sampled only in IDLE when load=1
//  rom_loader_load_received  out  1              word captured; held until load drops
//  rom_loader_ack            out  1              1-cycle pulse: word written, ready for next
//  mem_write_req             out  1              write request to ROM controller, held until done
//  mem_write_addr            out  ADDRESS_WIDTH  write address, stable while req=1
//  mem_write_data            out  DATA_WIDTH     write data, stable while req=1
//  mem_write_done            in   1              controller: write complete (sampled only while req=1)
//  words_loaded              out  ADDRESS_WIDTH+1 count of words accepted since last session reset
//  overflow                  out  1              sticky: a word arrived with ROM full
// BEHAVIOUR
//  - reset_n=0: immediately state=IDLE; all outputs, address, count, data register, pending flag = 0.
//  - All outputs registered. States: IDLE, RECEIVED, WRITE, ACK.
//  - IDLE: if rom_loader_reset=1 -> addr,words_loaded,overflow<=0, stay IDLE (priority over load).
//    else if load=1 -> capture data, load_received<=1, -> RECEIVED (load_received visible 1 cycle after load seen).
//  - RECEIVED: hold load_received=1 until load=0; then load_received<=0 and:
//    full (words_loaded[ADDRESS_WIDTH]=1) -> overflow<=1, no write, ack<=1, -> ACK;
//    else mem_write_req<=1, addr/data driven, -> WRITE.
//    rom_loader_reset=1 in RECEIVED -> discard word, clear counters, load_received<=0, -> IDLE.
//  - WRITE: req held high; when mem_write_done=1 -> req<=0, addr+1, words_loaded+1, ack<=1, -> ACK.
//    done in same cycle req first seen is legal (min write latency 1 cycle after req rises).
//    rom_loader_reset=1 in WRITE: set pending flag; req NOT dropped; on done -> clear counters/overflow,
//    no ack, -> IDLE. Pending flag cleared on that transition.
//  - ACK: ack=1 for exactly this cycle, -> IDLE. Load still high in ACK is ignored; re-sampled in IDLE.
//  - One write per load assertion; load held high across ACK counts as a new word only after returning to IDLE
//    (initiator must drop load before next word; protocol guarantees load=0 after received).
//  - Address wraps not allowed: after 2**ADDRESS_WIDTH words every further word sets overflow, is acked, not written.
//  - mem_write_done outside WRITE ignored. Overflow sticky until rom_loader_reset or reset_n.
// TESTING
//  1 reset_n=0 mid-WRITE -> same cycle req/ack/load_received=0, words_loaded=0; after release, first word goes to addr 0.
//  2 load=1 data=16'hABCD at cycle 0 -> load_received=1 at cycle 1; drop load cycle 2 -> req=1 addr=0 data=ABCD at cycle 3;
//    done at cycle 5 -> ack=1 only at cycle 6, words_loaded=1.
//  3 24 words 0x0100..0x0117, done latency random 0-5 -> writes addr 0..23 in order with matching data, 24 acks, words_loaded=24.
//  4 rom_loader_reset pulsed during WRITE of word 3 -> req held until done, no ack, words_loaded=0; next word -> addr 0.
//  5 ADDRESS_WIDTH=2, 5 words -> 4 writes (addr 0..3), 5th acked with no req, overflow=1 until rom_loader_reset.
//  6 load held high 10 cycles after received -> exactly one req; spurious done while IDLE -> no state change.

Source files
------------

// File: rtl/rom_loader_responder.sv
// Purpose: SoC-side ROM-loader responder; numbers incoming words 0,1,2... and writes each one to the ROM controller.
// Latency: load_received 1 cycle after load; write request 1 cycle after load drops; ack 1 cycle after write done.
// Backpressure: one word in flight; the initiator waits for ack, and the controller stalls us by withholding done.
module rom_loader_responder #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rom_loader_reset,
    input  logic                     rom_loader_load,
    input  logic [DATA_WIDTH-1:0]    rom_loader_data,
    output logic                     rom_loader_load_received,
    output logic                     rom_loader_ack,
    output logic                     mem_write_req,
    output logic [ADDRESS_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic                     mem_write_done,
    output logic [ADDRESS_WIDTH:0]   words_loaded,
    output logic                     overflow
);

    typedef enum logic [1:0] {S_IDLE, S_RECEIVED, S_WRITE, S_ACK} state_t;

    state_t                   r_state, w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [ADDRESS_WIDTH:0]   r_words, w_words_nxt;
    logic [DATA_WIDTH-1:0]    r_data, w_data_nxt;
    logic                     r_ovf, w_ovf_nxt;
    logic                     r_pend, w_pend_nxt;
    logic                     r_lr, w_lr_nxt;
    logic                     r_ack, w_ack_nxt;
    logic                     r_req, w_req_nxt;
    logic                     w_full;

    // ROM is full once exactly 2**ADDRESS_WIDTH words have been written
    assign w_full = r_words[ADDRESS_WIDTH];

    assign rom_loader_load_received = r_lr;
    assign rom_loader_ack           = r_ack;
    assign mem_write_req            = r_req;
    assign mem_write_addr           = r_addr;
    assign mem_write_data           = r_data;
    assign words_loaded             = r_words;
    assign overflow                 = r_ovf;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_words <= '0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_pend  <= 1'b0;
            r_lr    <= 1'b0;
            r_ack   <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_words <= w_words_nxt;
            r_data  <= w_data_nxt;
            r_ovf   <= w_ovf_nxt;
            r_pend  <= w_pend_nxt;
            r_lr    <= w_lr_nxt;
            r_ack   <= w_ack_nxt;
            r_req   <= w_req_nxt;
        end
    end

    // Handshake sequencing: next state and next register values
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_words_nxt = r_words;
        w_data_nxt  = r_data;
        w_ovf_nxt   = r_ovf;
        w_pend_nxt  = r_pend;
        w_lr_nxt    = r_lr;
        w_ack_nxt   = 1'b0;
        w_req_nxt   = r_req;
        case (r_state)
            S_IDLE: begin
                if (rom_loader_reset) begin
                    w_addr_nxt  = '0;
                    w_words_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                end else if (rom_loader_load) begin
                    w_data_nxt  = rom_loader_data;
                    w_lr_nxt    = 1'b1;
                    w_state_nxt = S_RECEIVED;
                end
            end
            S_RECEIVED: begin
                if (rom_loader_reset) begin
                    // abandon the captured word; nothing has been written yet
                    w_addr_nxt  = '0;
                    w_words_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                    w_lr_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (!rom_loader_load) begin
                    w_lr_nxt = 1'b0;
                    if (w_full) begin
                        // no room: ack so the initiator keeps going, but flag it
                        w_ovf_nxt   = 1'b1;
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = S_ACK;
                    end else begin
                        w_req_nxt   = 1'b1;
                        w_state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // a session reset cannot abort a write the controller already owns
                if (rom_loader_reset)
                    w_pend_nxt = 1'b1;
                if (mem_write_done) begin
                    w_req_nxt = 1'b0;
                    if (r_pend || rom_loader_reset) begin
                        w_addr_nxt  = '0;
                        w_words_nxt = '0;
                        w_ovf_nxt   = 1'b0;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_addr_nxt  = r_addr + ADDRESS_WIDTH'(1);
                        w_words_nxt = r_words + (ADDRESS_WIDTH + 1)'(1);
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = S_ACK;
                    end
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_loader_responder.sv
module tb_rom_loader_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, rl_reset, load, done, sel;
    logic [15:0] data;

    // instance A: 16-bit address space; instance B: 2-bit address space for the full-ROM case
    logic        a_lr, a_ack, a_req, a_ovf, b_lr, b_ack, b_req, b_ovf;
    logic [15:0] a_addr, a_wdata, b_wdata;
    logic [1:0]  b_addr;
    logic [16:0] a_words;
    logic [2:0]  b_words;
    logic        a_load, a_rst, a_done, b_load, b_rst, b_done;

    assign a_load = load & ~sel;
    assign a_rst  = rl_reset & ~sel;
    assign a_done = done & ~sel;
    assign b_load = load & sel;
    assign b_rst  = rl_reset & sel;
    assign b_done = done & sel;

    logic        o_lr, o_ack, o_req, o_ovf;
    logic [31:0] o_addr, o_wdata, o_words;
    assign o_lr    = sel ? b_lr : a_lr;
    assign o_ack   = sel ? b_ack : a_ack;
    assign o_req   = sel ? b_req : a_req;
    assign o_ovf   = sel ? b_ovf : a_ovf;
    assign o_addr  = sel ? 32'(b_addr) : 32'(a_addr);
    assign o_wdata = sel ? 32'(b_wdata) : 32'(a_wdata);
    assign o_words = sel ? 32'(b_words) : 32'(a_words);

    rom_loader_responder #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .rom_loader_reset(a_rst), .rom_loader_load(a_load),
        .rom_loader_data(data), .rom_loader_load_received(a_lr), .rom_loader_ack(a_ack),
        .mem_write_req(a_req), .mem_write_addr(a_addr), .mem_write_data(a_wdata),
        .mem_write_done(a_done), .words_loaded(a_words), .overflow(a_ovf)
    );

    rom_loader_responder #(.DATA_WIDTH(16), .ADDRESS_WIDTH(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .rom_loader_reset(b_rst), .rom_loader_load(b_load),
        .rom_loader_data(data), .rom_loader_load_received(b_lr), .rom_loader_ack(b_ack),
        .mem_write_req(b_req), .mem_write_addr(b_addr), .mem_write_data(b_wdata),
        .mem_write_done(b_done), .words_loaded(b_words), .overflow(b_ovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: words written this session, ROM capacity, sticky overflow
    int m_count;
    int m_cap;
    bit m_ovf;
    int n_acks;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock and settle just after the edge; inputs are changed here too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic session_reset();
        rl_reset = 1'b1;
        tick();
        rl_reset = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;
        chk("sess_rst_words", o_words, 32'd0);
        chk("sess_rst_ovf", {31'd0, o_ovf}, {31'd0, m_ovf});
    endtask

    // one full handshake: load held for 'hold' extra cycles, done after 'lat' cycles of req,
    // optional session reset while the write is outstanding
    task automatic send_word(input logic [15:0] d, input int lat, input int hold, input bit rst_in_write);
        int exp_addr;
        load = 1'b1;
        data = d;
        tick();
        chk("lr_rise", {31'd0, o_lr}, 32'd1);
        chk("no_early_req", {31'd0, o_req}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("lr_hold", {31'd0, o_lr}, 32'd1);
            chk("req_while_load", {31'd0, o_req}, 32'd0);
        end
        load = 1'b0;
        data = 16'($urandom);
        tick();
        chk("lr_fall", {31'd0, o_lr}, 32'd0);
        if (m_count >= m_cap) begin
            m_ovf = 1'b1;
            n_acks++;
            chk("full_ack", {31'd0, o_ack}, 32'd1);
            chk("full_no_req", {31'd0, o_req}, 32'd0);
            chk("full_ovf", {31'd0, o_ovf}, 32'd1);
            chk("full_words", o_words, 32'(m_count));
            tick();
            chk("full_ack_pulse", {31'd0, o_ack}, 32'd0);
            return;
        end
        exp_addr = m_count;
        chk("req_rise", {31'd0, o_req}, 32'd1);
        chk("wr_addr", o_addr, 32'(exp_addr));
        chk("wr_data", o_wdata, 32'(d));
        for (int i = 0; i < lat; i++) begin
            if (rst_in_write && i == 0) rl_reset = 1'b1;
            tick();
            rl_reset = 1'b0;
            chk("req_held", {31'd0, o_req}, 32'd1);
            chk("addr_stable", o_addr, 32'(exp_addr));
            chk("no_ack_wait", {31'd0, o_ack}, 32'd0);
        end
        if (rst_in_write && lat == 0) rl_reset = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        rl_reset = 1'b0;
        chk("req_drop", {31'd0, o_req}, 32'd0);
        if (rst_in_write) begin
            m_count = 0;
            m_ovf   = 1'b0;
            chk("rst_no_ack", {31'd0, o_ack}, 32'd0);
            chk("rst_words", o_words, 32'd0);
            chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
        end else begin
            m_count++;
            n_acks++;
            chk("ack", {31'd0, o_ack}, 32'd1);
            chk("words", o_words, 32'(m_count));
        end
        tick();
        chk("ack_pulse", {31'd0, o_ack}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; rl_reset = 1'b0; load = 1'b0; done = 1'b0; sel = 1'b0; data = '0;
        m_count = 0; m_cap = 65536; m_ovf = 1'b0; n_acks = 0;
        tick();
        chk("por_lr", {31'd0, o_lr}, 32'd0);
        chk("por_req", {31'd0, o_req}, 32'd0);
        chk("por_words", o_words, 32'd0);
        reset_n = 1'b1;
        tick();

        // a few words, then reset_n while a write is outstanding
        send_word(16'h1111, 1, 0, 1'b0);
        send_word(16'h2222, 0, 0, 1'b0);
        load = 1'b1; data = 16'h3333;
        tick();
        load = 1'b0;
        tick();
        chk("pre_rst_req", {31'd0, o_req}, 32'd1);
        chk("pre_rst_addr", o_addr, 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, o_req}, 32'd0);
        chk("arst_ack", {31'd0, o_ack}, 32'd0);
        chk("arst_lr", {31'd0, o_lr}, 32'd0);
        chk("arst_words", o_words, 32'd0);
        m_count = 0; m_ovf = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        send_word(16'h4444, 2, 0, 1'b0);

        // directed timing: load two cycles, done two cycles after req
        session_reset();
        send_word(16'hABCD, 2, 1, 1'b0);

        // 24 sequential words with random done latency and load hold
        session_reset();
        n_acks = 0;
        for (int i = 0; i < 24; i++)
            send_word(16'h0100 + 16'(i), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b0);
        chk("seq_words", o_words, 32'd24);
        chk("seq_acks", 32'(n_acks), 32'd24);

        // session reset during the write of word 3
        session_reset();
        for (int i = 0; i < 3; i++)
            send_word(16'($urandom), int'($urandom_range(0, 3)), 0, 1'b0);
        send_word(16'hBEEF, 3, 0, 1'b1);
        send_word(16'hC0DE, int'($urandom_range(0, 3)), 0, 1'b0);
        send_word(16'h5A5A, 0, 0, 1'b1);
        send_word(16'hC0DF, 1, 0, 1'b0);

        // small ROM: four writes, then overflowing words
        sel = 1'b1;
        m_cap = 4; m_count = 0; m_ovf = 1'b0;
        tick();
        chk("b_start_ovf", {31'd0, o_ovf}, 32'd0);
        for (int i = 0; i < 5; i++)
            send_word(16'h0A00 + 16'(i), int'($urandom_range(0, 4)), 0, 1'b0);
        repeat (3) tick();
        chk("ovf_sticky", {31'd0, o_ovf}, 32'd1);
        chk("full_count", o_words, 32'd4);
        send_word(16'h0AFF, 1, 0, 1'b0);
        session_reset();
        send_word(16'h0B00, 1, 0, 1'b0);

        // long load hold gives one request; stray done in IDLE is ignored
        sel = 1'b0;
        m_cap = 65536;
        session_reset();
        send_word(16'h7777, 1, 10, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("stray_req", {31'd0, o_req}, 32'd0);
        chk("stray_ack", {31'd0, o_ack}, 32'd0);
        chk("stray_words", o_words, 32'(m_count));
        send_word(16'h8888, 2, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
